// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave
//   Burst memory slave with independent, concurrently running write and read
//   channels. Each beat address is range-checked; beats past the top of the
//   memory never wrap: writes are dropped and reads return zero, both flagged
//   SLVERR. Storage is not reset.
//
// Ports
//   clk, a_rst_n                 clock, asynchronous active-low reset
//   AWVALID/AWREADY, AWADDR, AWLEN   write address channel (LEN = beats-1)
//   WVALID/WREADY, WDATA, WLAST      write data channel
//   BVALID/BREADY, BRESP             write response (00 OKAY, 10 SLVERR)
//   ARVALID/ARREADY, ARADDR, ARLEN   read address channel
//   RVALID/RREADY, RDATA, RRESP, RLAST  read data channel
module axi_burst_mem_slave #(
    parameter int DATA_W = 8,
    parameter int MEM_AW = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [MEM_AW-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [MEM_AW-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST
);

    localparam int DEPTH = 2**MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t          w_state;
    logic [MEM_AW:0]   waddr;     // one extra bit detects DEPTH-1 -> DEPTH
    logic [LEN_W-1:0]  wlen;
    logic [LEN_W-1:0]  wcnt;
    logic              werr;
    logic              wovf;      // sticky: once past the top, stay out of range

    logic w_beat;
    logic w_oob;
    logic w_last_beat;
    logic werr_next;
    logic mem_we;

    always_comb begin
        w_beat      = (w_state == W_DATA) && WVALID && WREADY;
        w_oob       = waddr[MEM_AW] || wovf;
        w_last_beat = (wcnt == wlen);
        // Burst length comes from AWLEN alone; a misplaced WLAST only flags an error.
        werr_next   = werr || w_oob || (WLAST != w_last_beat);
        mem_we      = w_beat && !w_oob;
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            w_state <= W_IDLE;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
            wovf    <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        waddr   <= {1'b0, AWADDR};
                        wlen    <= AWLEN;
                        wcnt    <= '0;
                        werr    <= 1'b0;
                        wovf    <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        waddr <= waddr + 1'b1;
                        wcnt  <= wcnt + 1'b1;
                        werr  <= werr_next;
                        if (w_oob) begin
                            wovf <= 1'b1;
                        end
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= werr_next ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= RESP_OKAY;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr[MEM_AW-1:0]] <= WDATA;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t          r_state;
    logic [MEM_AW:0]   raddr;
    logic [LEN_W-1:0]  rlen;
    logic [LEN_W-1:0]  rcnt;
    logic              rovf;
    logic              r_oob;

    always_comb begin
        r_oob = raddr[MEM_AW] || rovf;
    end

    // Reads sample mem with a non-blocking load, so a same-edge write to the
    // same word is not yet visible: the read returns the old contents.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state <= R_IDLE;
            raddr   <= '0;
            rlen    <= '0;
            rcnt    <= '0;
            rovf    <= 1'b0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        // ARADDR is MEM_AW bits wide, so the first beat is always in range.
                        RDATA   <= mem[ARADDR];
                        RRESP   <= RESP_OKAY;
                        RVALID  <= 1'b1;
                        RLAST   <= (ARLEN == '0);
                        raddr   <= {1'b0, ARADDR} + 1'b1;
                        rlen    <= ARLEN;
                        rcnt    <= CNT_ONE;
                        rovf    <= 1'b0;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            if (r_oob) begin
                                RDATA <= '0;
                                RRESP <= RESP_SLVERR;
                                rovf  <= 1'b1;
                            end else begin
                                RDATA <= mem[raddr[MEM_AW-1:0]];
                                RRESP <= RESP_OKAY;
                            end
                            RLAST <= (rcnt == rlen);
                            raddr <= raddr + 1'b1;
                            rcnt  <= rcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb_axi_burst_mem_slave
//   Directed bench for axi_burst_mem_slave: a table of write/read bursts with
//   hand-chosen addresses, lengths and expected write responses, plus
//   hand-written sequences for the same-edge collision and mid-burst reset.
//   Read data expectations come from a reference memory image built from the
//   bursts the bench itself issued.
module tb_axi_burst_mem_slave;

    logic       clk;
    logic       a_rst_n;
    logic       AWVALID;
    logic       AWREADY;
    logic [7:0] AWADDR;
    logic [3:0] AWLEN;
    logic       WVALID;
    logic       WREADY;
    logic [7:0] WDATA;
    logic       WLAST;
    logic       BVALID;
    logic       BREADY;
    logic [1:0] BRESP;
    logic       ARVALID;
    logic       ARREADY;
    logic [7:0] ARADDR;
    logic [3:0] ARLEN;
    logic       RVALID;
    logic       RREADY;
    logic [7:0] RDATA;
    logic [1:0] RRESP;
    logic       RLAST;

    axi_burst_mem_slave #(
        .DATA_W (8),
        .MEM_AW (8),
        .LEN_W  (4)
    ) dut (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WLAST   (WLAST),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [256];
    bit         model_ok  [256];

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [3:0] len;
        int         wlast_beat;
        logic [7:0] base;
        logic [1:0] exp_bresp;
        bit         stall;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input int wlast_beat,
                            input logic [7:0] base, input logic [1:0] exp_resp, input string tag);
        int t;
        int a;
        AWADDR  = addr;
        AWLEN   = len;
        AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!AWREADY) timeout_fail({tag, " awready"});
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk({tag, " awready drop"}, AWREADY, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1;
            WDATA  = base + 8'(i);
            WLAST  = (i == wlast_beat);
            t = 0;
            while (!WREADY && t < 20) begin
                @(posedge clk); #1; t++;
            end
            if (!WREADY) timeout_fail($sformatf("%s wready beat %0d", tag, i));
            @(posedge clk); #1;
            a = int'(addr) + i;
            if (a < 256) begin
                model_mem[a] = base + 8'(i);
                model_ok[a]  = 1'b1;
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        chk({tag, " bvalid"}, BVALID, 1'b1);
        chk({tag, " bresp"}, BRESP, exp_resp);
        chk({tag, " wready drop"}, WREADY, 1'b0);
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        chk({tag, " bvalid clear"}, BVALID, 1'b0);
        chk({tag, " awready back"}, AWREADY, 1'b1);
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] addr, input int i, input logic [3:0] len);
        int a;
        logic [7:0] ed;
        logic [1:0] er;
        a = int'(addr) + i;
        if (a < 256) begin
            ed = model_mem[a];
            er = 2'b00;
        end else begin
            ed = 8'h00;
            er = 2'b10;
        end
        chk($sformatf("%s rvalid b%0d", tag, i), RVALID, 1'b1);
        if (a >= 256 || model_ok[a])
            chk($sformatf("%s rdata b%0d", tag, i), RDATA, ed);
        chk($sformatf("%s rresp b%0d", tag, i), RRESP, er);
        chk($sformatf("%s rlast b%0d", tag, i), RLAST, (i == int'(len)));
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input bit stall, input string tag);
        int t;
        ARADDR  = addr;
        ARLEN   = len;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        t = 0;
        while (!ARREADY && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!ARREADY) timeout_fail({tag, " arready"});
        @(posedge clk); #1;
        ARVALID = 1'b0;
        chk({tag, " arready drop"}, ARREADY, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            if (stall && (i % 2 == 1)) begin
                RREADY = 1'b0;
                repeat (2) begin
                    chk_beat({tag, " stall"}, addr, i, len);
                    @(posedge clk); #1;
                end
            end
            RREADY = 1'b1;
            chk_beat(tag, addr, i, len);
            @(posedge clk); #1;
        end
        RREADY = 1'b0;
        chk({tag, " rvalid clear"}, RVALID, 1'b0);
        chk({tag, " arready back"}, ARREADY, 1'b1);
    endtask

    initial begin
        int t;
        a_rst_n = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWLEN = '0;
        WVALID  = 1'b0; WDATA  = '0; WLAST = 1'b0;
        BREADY  = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; ARLEN = '0;
        RREADY  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            model_ok[i]  = 1'b0;
        end

        //           wr    addr   len  wlast base   bresp  stall
        vecs[0]  = '{1'b1, 8'h10, 4'd3,  3, 8'hA1, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 4'd3,  0, 8'h00, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 8'h10, 4'd3,  0, 8'h00, 2'b00, 1'b1};
        vecs[3]  = '{1'b1, 8'h00, 4'd1,  1, 8'h30, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 8'hFE, 4'd3,  3, 8'hE0, 2'b10, 1'b0};
        vecs[5]  = '{1'b0, 8'hFE, 4'd3,  0, 8'h00, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 4'd1,  0, 8'h00, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 8'h40, 4'd3,  1, 8'hB0, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 8'h40, 4'd3,  0, 8'h00, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 8'h20, 4'd0,  0, 8'h55, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 8'h80, 4'd15, 15, 8'h00, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 8'h80, 4'd15, 0, 8'h00, 2'b00, 1'b1};
        vecs[12] = '{1'b0, 8'h13, 4'd0,  0, 8'h00, 2'b00, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst awready", AWREADY, 1'b0);
        chk("rst wready",  WREADY,  1'b0);
        chk("rst bvalid",  BVALID,  1'b0);
        chk("rst bresp",   BRESP,   2'b00);
        chk("rst arready", ARREADY, 1'b0);
        chk("rst rvalid",  RVALID,  1'b0);
        chk("rst rdata",   RDATA,   8'h00);
        chk("rst rresp",   RRESP,   2'b00);
        chk("rst rlast",   RLAST,   1'b0);
        @(negedge clk);
        a_rst_n = 1'b1;
        #1;
        chk("release awready before edge", AWREADY, 1'b0);
        @(posedge clk); #1;
        chk("release awready", AWREADY, 1'b1);
        chk("release arready", ARREADY, 1'b1);

        for (int k = 0; k < NVEC; k++) begin
            if (vecs[k].is_wr)
                do_write(vecs[k].addr, vecs[k].len, vecs[k].wlast_beat, vecs[k].base,
                         vecs[k].exp_bresp, $sformatf("v%0d wr", k));
            else
                do_read(vecs[k].addr, vecs[k].len, vecs[k].stall, $sformatf("v%0d rd", k));
            @(posedge clk); #1;
        end

        // Same-edge collision at 0x20 (holds 0x55): write beat and read load together.
        AWADDR = 8'h20; AWLEN = 4'd0; AWVALID = 1'b1;
        t = 0;
        while (!(AWREADY && ARREADY) && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!(AWREADY && ARREADY)) timeout_fail("coll idle");
        @(posedge clk); #1;
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 8'h99; WLAST = 1'b1;
        ARVALID = 1'b1; ARADDR = 8'h20; ARLEN = 4'd0;
        chk("coll wready", WREADY, 1'b1);
        chk("coll arready", ARREADY, 1'b1);
        @(posedge clk); #1;
        WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
        chk("coll rvalid", RVALID, 1'b1);
        chk("coll rdata old", RDATA, 8'h55);
        chk("coll rlast", RLAST, 1'b1);
        chk("coll bvalid", BVALID, 1'b1);
        chk("coll bresp", BRESP, 2'b00);
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        model_mem[8'h20] = 8'h99;
        @(posedge clk); #1;
        do_read(8'h20, 4'd0, 1'b0, "coll reread");
        @(posedge clk); #1;

        // Reset during beat 2 of a read burst
        ARADDR = 8'h10; ARLEN = 4'd3; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!ARREADY) timeout_fail("rstmid arready");
        @(posedge clk); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        chk("rstmid beat1", RDATA, 8'hA1);
        @(posedge clk); #1;
        chk("rstmid beat2", RDATA, 8'hA2);
        a_rst_n = 1'b0;
        #1;
        RREADY = 1'b0;
        chk("rstmid rvalid", RVALID, 1'b0);
        chk("rstmid rlast", RLAST, 1'b0);
        chk("rstmid rdata", RDATA, 8'h00);
        chk("rstmid arready", ARREADY, 1'b0);
        chk("rstmid awready", AWREADY, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid arready back", ARREADY, 1'b1);
        chk("rstmid awready back", AWREADY, 1'b1);
        do_read(8'h10, 4'd3, 1'b0, "post rst rd");
        @(posedge clk); #1;
        do_write(8'h60, 4'd1, 1, 8'h71, 2'b00, "post rst wr");
        @(posedge clk); #1;
        do_read(8'h60, 4'd1, 1'b0, "post rst rd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

Parametrised burst memory slave with independent write and read channels. It replaces the single-channel, mode-switched memory slave: both channels run concurrently, burst length comes from an explicit length field, and each beat's address is checked against the memory bounds. It sits behind the task-scheduler master as its backing store.

## Interface
- DATA_W, 8, data width in bits.
- MEM_AW, 8, memory address width; DEPTH = 2**MEM_AW words.
- LEN_W, 4, burst-length field width; a burst is LEN+1 beats, maximum 2**LEN_W.
- Reset is asynchronous and active-low. One clock.
- clk  in  1  clock; all logic on the rising edge.
- a_rst_n  in  1  asynchronous active-low reset.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- AWADDR  in  MEM_AW  start address of the write burst.
- AWLEN  in  LEN_W  write beats minus 1.
- WVALID / WREADY  in / out  1  write-data handshake.
- WDATA  in  DATA_W  write data.
- WLAST  in  1  master's last-beat marker.
- BVALID / BREADY  out / in  1  write-response handshake.
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- ARADDR  in  MEM_AW  start address of the read burst.
- ARLEN  in  LEN_W  read beats minus 1.
- RVALID / RREADY  out / in  1  read-data handshake.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  per-beat response, same encoding as BRESP.
- RLAST  out  1  final read beat.

## Operation
- Storage: DEPTH x DATA_W array. It is not cleared by reset; contents are undefined until written.
- Write FSM has three states.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch the address into waddr and AWLEN into wlen, clear the beat counter wcnt and the error flag werr, and go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY beat is one write.
    - If waddr <= DEPTH-1 and no overflow has occurred, write mem[waddr]=WDATA. Otherwise suppress the write and set werr.
    - Advance waddr by 1 and wcnt by 1.
    - Set werr if WLAST != (wcnt==wlen).
    - The burst ends on the beat where wcnt==wlen, regardless of WLAST; go to W_RESP.
  - W_RESP: BVALID=1, BRESP = werr ? 2'b10 : 2'b00. On BREADY, go to W_IDLE.
- Read FSM has two states.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY:
    - Load RDATA with mem[ARADDR], or 0 if out of range.
    - Set RRESP to match, RVALID=1, RLAST=(ARLEN==0).
    - Latch raddr=ARADDR+1 and rcnt=1, then go to R_DATA.
  - R_DATA: on RVALID&RREADY:
    - If RLAST, drop RVALID and RLAST and go to R_IDLE.
    - Otherwise load the next beat from raddr (same range rule), set RLAST=(rcnt==rlen), and increment raddr and rcnt.
    - While RREADY=0, RDATA, RRESP and RLAST hold stable.
- Address arithmetic uses MEM_AW+1 bits internally so that DEPTH-1 -> DEPTH is detected. There is no wrap-around: every beat past the top address is SLVERR (write suppressed, read data 0). Beats before the overflow complete normally.
- The channels are fully independent; a read and a write may be in flight together.
- Same-address collision on one edge (write beat and read-beat load): the read returns the old data.
- Reset asserted mid-burst: both FSMs return to idle immediately and the partial burst is abandoned. Words already written stay written.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RDATA=0, RRESP=0, RLAST=0.
- All outputs are registered.
- AWREADY and ARREADY go to 1 on the first edge after a_rst_n deasserts.
- AWREADY, WREADY and ARREADY drop on the edge after their handshake.
- Write: one AW cycle. W beats may then stream at 1 per cycle. BVALID rises on the edge after the last beat is accepted, and AWREADY returns on the edge after BVALID&BREADY.
- Read: RVALID is visible the cycle after the AR handshake. Beats stream at 1 per cycle while RREADY=1. ARREADY returns on the edge after the RLAST handshake.
- Minimum burst-to-burst gap is 1 idle cycle per channel.

## Test plan
- Reset, then write burst AWADDR=0x10, AWLEN=3, WDATA=A1,A2,A3,A4 with WLAST on beat 4 -> BRESP=00. Then read ARADDR=0x10, ARLEN=3 with RREADY=1 -> RDATA A1..A4 on consecutive cycles, RLAST on beat 4, RRESP=00.
- Read burst with RREADY toggling 1,0,0,1,... -> each beat's RDATA, RRESP and RLAST stay stable across stall cycles; no beat is lost or duplicated.
- Write AWADDR=0xFE, AWLEN=3 -> mem[0xFE] and mem[0xFF] written, mem[0x00] and mem[0x01] unchanged, BRESP=10. Read the same burst -> RRESP 00,00,10,10 with RDATA=0 on the last two beats.
- WLAST on beat 2 of a 4-beat burst -> all 4 beats accepted, BRESP=10.
- Concurrent write to 0x20 and read of 0x20 colliding on the same edge -> the read returns the prior value; a subsequent read returns the new value.
- Assert a_rst_n low during beat 2 of a read burst -> RVALID=0 immediately; ARREADY=1 one edge after release; a new burst completes normally.
